level_sequencer: RTL and testbench

//   Registered level/room sequencer for the game top level. It replaces the combinational

---
 rtl/level_sequencer.sv | 151 +++++++++++++++
 tb/tb_level_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_sequencer.sv
// Registered level/room sequencer: latches level requests, handshakes loads with the
// room/sprite loader and auto-advances on level completion. Optional macro: LEVEL_SPLASH_EN.
module level_sequencer #(
  parameter int unsigned NUM_LEVELS    = 3,
  parameter int unsigned SEL_W         = 10,
  parameter int unsigned LEVEL_W       = 3,
  parameter bit          WRAP          = 1'b0,
  parameter int unsigned SPLASH_CYCLES = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
  input  logic               level_done,
  input  logic               load_ack,
  output logic [LEVEL_W-1:0] level_out,
  output logic               load_req,
  output logic               playing,
  output logic               splash,
  output logic               game_complete
);

  if (NUM_LEVELS >= (1 << LEVEL_W)) begin : g_bad_level_w
    $error("level_sequencer: NUM_LEVELS must be < 2**LEVEL_W");
  end
  if (LEVEL_W > SEL_W) begin : g_bad_sel_w
    $error("level_sequencer: LEVEL_W must not exceed SEL_W");
  end
  if (SPLASH_CYCLES == 0) begin : g_bad_splash
    $error("level_sequencer: SPLASH_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    StTitle = 2'd0,
    StLoad  = 2'd1,
`ifdef LEVEL_SPLASH_EN
    StSplash = 2'd2,
`endif
    StPlay  = 2'd3
  } state_e;

  localparam logic [SEL_W-1:0]   SelMax    = SEL_W'(NUM_LEVELS);
  localparam logic [LEVEL_W-1:0] LastLevel = LEVEL_W'(NUM_LEVELS);

  state_e state_q;

  // Range check at full SEL_W so high bits can never alias onto a valid level.
  logic               valid_req;
  logic               title_req;
  logic [LEVEL_W-1:0] sel_level;

  assign valid_req = sel_valid && (sel != '0) && (sel <= SelMax);
  assign title_req = sel_valid && (sel == '0);
  assign sel_level = sel[LEVEL_W-1:0];

`ifdef LEVEL_SPLASH_EN
  localparam int unsigned CntW = $clog2(SPLASH_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SPLASH_CYCLES - 1);

  logic [CntW-1:0] splash_cnt_q;
`else
  assign splash = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StTitle;
      level_out     <= '0;
      load_req      <= 1'b0;
      playing       <= 1'b0;
      game_complete <= 1'b0;
`ifdef LEVEL_SPLASH_EN
      splash        <= 1'b0;
      splash_cnt_q  <= '0;
`endif
    end else begin
      game_complete <= 1'b0;
      unique case (state_q)
        StTitle: begin
          if (valid_req) begin
            level_out <= sel_level;
            load_req  <= 1'b1;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          if (load_ack) begin
            load_req <= 1'b0;
`ifdef LEVEL_SPLASH_EN
            splash       <= 1'b1;
            splash_cnt_q <= '0;
            state_q      <= StSplash;
`else
            playing <= 1'b1;
            state_q <= StPlay;
`endif
          end
        end
`ifdef LEVEL_SPLASH_EN
        StSplash: begin
          if (splash_cnt_q == LastCnt) begin
            splash       <= 1'b0;
            splash_cnt_q <= '0;
            playing      <= 1'b1;
            state_q      <= StPlay;
          end else begin
            splash_cnt_q <= splash_cnt_q + CntW'(1);
          end
        end
`endif
        StPlay: begin
          // Level completion outranks any request arriving in the same cycle.
          if (level_done) begin
            playing <= 1'b0;
            if (level_out < LastLevel) begin
              level_out <= level_out + LEVEL_W'(1);
              load_req  <= 1'b1;
              state_q   <= StLoad;
            end else begin
              game_complete <= 1'b1;
              if (WRAP) begin
                level_out <= LEVEL_W'(1);
                load_req  <= 1'b1;
                state_q   <= StLoad;
              end else begin
                level_out <= '0;
                state_q   <= StTitle;
              end
            end
          end else if (valid_req) begin
            playing   <= 1'b0;
            level_out <= sel_level;
            load_req  <= 1'b1;
            state_q   <= StLoad;
          end else if (title_req) begin
            playing   <= 1'b0;
            level_out <= '0;
            state_q   <= StTitle;
          end
        end
        default: begin
          state_q   <= StTitle;
          level_out <= '0;
          load_req  <= 1'b0;
          playing   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer: behavioural model compared every cycle plus
// directed literal checks. Honours LEVEL_SPLASH_EN when defined.
module tb_level_sequencer;

  localparam int NUM_LEVELS = 3;
  localparam int SEL_W      = 10;
  localparam int LEVEL_W    = 3;
  localparam bit WRAP       = 1'b0;
`ifdef LEVEL_SPLASH_EN
  localparam int SPLASH_CYCLES = 4;
  localparam bit SPLASH_ON     = 1'b1;
`else
  localparam int SPLASH_CYCLES = 120;
  localparam bit SPLASH_ON     = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [SEL_W-1:0]   sel = '0;
  logic               sel_valid = 1'b0;
  logic               level_done = 1'b0;
  logic               load_ack = 1'b0;
  logic [LEVEL_W-1:0] level_out;
  logic               load_req;
  logic               playing;
  logic               splash;
  logic               game_complete;

  int checks = 0;
  int errors = 0;

  level_sequencer #(
    .NUM_LEVELS    (NUM_LEVELS),
    .SEL_W         (SEL_W),
    .LEVEL_W       (LEVEL_W),
    .WRAP          (WRAP),
    .SPLASH_CYCLES (SPLASH_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sel           (sel),
    .sel_valid     (sel_valid),
    .level_done    (level_done),
    .load_ack      (load_ack),
    .level_out     (level_out),
    .load_req      (load_req),
    .playing       (playing),
    .splash        (splash),
    .game_complete (game_complete)
  );

  always #5 clk = ~clk;

  // Model: which phase of the game we are in, the current room, and splash time left.
  typedef enum int {MTitle, MLoad, MSplash, MPlay} phase_e;
  phase_e m_phase = MTitle;
  int     m_level = 0;
  int     m_splash_left = 0;
  bit     m_gc = 1'b0;

  always @(posedge clk or posedge reset) begin
    bit req_ok;
    if (reset) begin
      m_phase = MTitle;
      m_level = 0;
      m_splash_left = 0;
      m_gc = 1'b0;
    end else begin
      req_ok = sel_valid && (int'(sel) >= 1) && (int'(sel) <= NUM_LEVELS);
      m_gc = 1'b0;
      case (m_phase)
        MTitle: if (req_ok) begin
          m_level = int'(sel);
          m_phase = MLoad;
        end
        MLoad: if (load_ack) begin
          if (SPLASH_ON) begin
            m_phase = MSplash;
            m_splash_left = SPLASH_CYCLES;
          end else begin
            m_phase = MPlay;
          end
        end
        MSplash: begin
          m_splash_left = m_splash_left - 1;
          if (m_splash_left == 0) m_phase = MPlay;
        end
        MPlay: begin
          if (level_done) begin
            if (m_level == NUM_LEVELS) begin
              m_gc = 1'b1;
              m_level = WRAP ? 1 : 0;
              m_phase = WRAP ? MLoad : MTitle;
            end else begin
              m_level = m_level + 1;
              m_phase = MLoad;
            end
          end else if (req_ok) begin
            m_level = int'(sel);
            m_phase = MLoad;
          end else if (sel_valid && sel == '0) begin
            m_level = 0;
            m_phase = MTitle;
          end
        end
        default: m_phase = MTitle;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (level_out !== LEVEL_W'(m_level) || load_req !== (m_phase == MLoad) ||
          playing !== (m_phase == MPlay) || splash !== (m_phase == MSplash) ||
          game_complete !== m_gc) begin
        errors++;
        $display("FAIL model t=%0t: got level=%0d req=%b play=%b splash=%b gc=%b, need level=%0d req=%b play=%b splash=%b gc=%b",
                 $time, level_out, load_req, playing, splash, game_complete, m_level,
                 m_phase == MLoad, m_phase == MPlay, m_phase == MSplash, m_gc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock with the given inputs sampled at the edge; returns 1 time unit after it.
  task automatic tick(input bit sv, input int s, input bit done, input bit ack);
    sel_valid  = sv;
    sel        = SEL_W'(s);
    level_done = done;
    load_ack   = ack;
    @(posedge clk);
    #1;
    sel_valid  = 1'b0;
    sel        = '0;
    level_done = 1'b0;
    load_ack   = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    check("reset_level", 32'(level_out), 0);
    check("reset_load_req", 32'(load_req), 0);
    check("reset_playing", 32'(playing), 0);
    check("reset_gc", 32'(game_complete), 0);

    // Title ignores Sel=0 and out-of-range or aliasing requests.
    tick(1, 0, 0, 0);
    tick(1, 5, 0, 0);
    tick(1, 'h009, 0, 0);
    check("title_ignore_level", 32'(level_out), 0);
    check("title_ignore_req", 32'(load_req), 0);

    // Start level 1, ack three cycles later.
    tick(1, 1, 0, 0);
    check("start_level", 32'(level_out), 1);
    check("start_req", 32'(load_req), 1);
    check("start_playing", 32'(playing), 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
`ifndef LEVEL_SPLASH_EN
    check("ack_req_drop", 32'(load_req), 0);
    check("ack_playing", 32'(playing), 1);

    // Stray ack while playing changes nothing.
    tick(0, 0, 0, 1);
    check("stray_ack_playing", 32'(playing), 1);
    check("stray_ack_req", 32'(load_req), 0);

    // Advance 1->2, inputs ignored during load, 2->3, then finish the game.
    tick(0, 0, 1, 0);
    check("adv2_level", 32'(level_out), 2);
    check("adv2_req", 32'(load_req), 1);
    tick(1, 3, 1, 0);
    check("load_ignores_level", 32'(level_out), 2);
    check("load_ignores_req", 32'(load_req), 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 1, 0);
    check("adv3_level", 32'(level_out), 3);
    tick(0, 0, 0, 1);
    tick(0, 0, 1, 0);
    check("end_gc", 32'(game_complete), 1);
    check("end_level", 32'(level_out), 0);
    check("end_playing", 32'(playing), 0);
    check("end_req", 32'(load_req), 0);
    tick(0, 0, 0, 0);
    check("end_gc_pulse", 32'(game_complete), 0);

    // Invalid and aliasing warps at level 2, then Sel=0 back to title.
    tick(1, 2, 0, 0);
    tick(0, 0, 0, 1);
    tick(1, 4, 0, 0);
    tick(1, 'h009, 0, 0);
    tick(1, 'h3FF, 0, 0);
    check("invalid_level", 32'(level_out), 2);
    check("invalid_playing", 32'(playing), 1);
    check("invalid_req", 32'(load_req), 0);
    tick(1, 0, 0, 0);
    check("sel0_level", 32'(level_out), 0);
    check("sel0_playing", 32'(playing), 0);

    // Level_Done beats a simultaneous warp request.
    tick(1, 1, 0, 0);
    tick(0, 0, 0, 1);
    tick(1, 3, 1, 0);
    check("conflict_level", 32'(level_out), 2);
    check("conflict_req", 32'(load_req), 1);
    tick(0, 0, 0, 1);

    // Warp to the current level still reloads it.
    tick(1, 2, 0, 0);
    check("warp_same_level", 32'(level_out), 2);
    check("warp_same_req", 32'(load_req), 1);

    // Asynchronous reset in the middle of the load.
    #2 reset = 1'b1;
    #1;
    check("async_rst_level", 32'(level_out), 0);
    check("async_rst_req", 32'(load_req), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick(0, 0, 0, 1);
    check("post_rst_ack_req", 32'(load_req), 0);
    check("post_rst_ack_playing", 32'(playing), 0);
    check("post_rst_ack_level", 32'(level_out), 0);
`else
    // Ack at edge N: splash high after N..N+3, playing after N+4; requests ignored.
    check("splash_on", 32'(splash), 1);
    check("splash_req_drop", 32'(load_req), 0);
    check("splash_not_playing", 32'(playing), 0);
    tick(1, 3, 0, 0);
    check("splash_ignores_level", 32'(level_out), 1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check("splash_still_on", 32'(splash), 1);
    check("splash_still_not_playing", 32'(playing), 0);
    tick(0, 0, 0, 0);
    check("splash_off", 32'(splash), 0);
    check("splash_then_playing", 32'(playing), 1);
    check("splash_level_kept", 32'(level_out), 1);
    tick(0, 0, 1, 0);
    check("splash_adv_level", 32'(level_out), 2);
    check("splash_adv_req", 32'(load_req), 1);
`endif

    tick(0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
